card_board: RTL and testbench

//  Card-board store and click responder on the far side of the game controller's card interface.

---
 rtl/card_board_pkg.sv | 30 +++
 rtl/card_board_if.sv | 38 +++
 rtl/card_hit_scanner.sv | 86 ++++++++
 rtl/card_board.sv | 114 +++++++++++
 tb/tb_card_board.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/card_board_pkg.sv
// Shared definitions for the card board: board geometry, card state encodings
// and click-scanner states, shared with the game controller.
package card_board_pkg;

    localparam int N_CARDS = 12;
    localparam int COLS    = 4;
    localparam int X0      = 64;
    localparam int Y0      = 64;
    localparam int CARD_W  = 128;
    localparam int CARD_H  = 160;
    localparam int GAP     = 32;

    typedef enum logic [1:0] {
        CARD_BLANK     = 2'b00,
        CARD_COVERED   = 2'b01,
        CARD_REMOVED   = 2'b10,
        CARD_UNCOVERED = 2'b11
    } card_state_e;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'b00,
        SCAN_RUN  = 2'b01,
        SCAN_HIT  = 2'b10
    } scan_state_e;

    function automatic logic addr_valid(input logic [3:0] addr);
        return (addr < 4'(N_CARDS));
    endfunction

endpackage

// File: rtl/card_board_if.sv
// Card interface between the game controller/renderer side and the card board.
interface card_board_if;
    logic        color_wr_en;
    logic [3:0]  color_wr_addr;
    logic [11:0] color_wr_data;
    logic        write_card_en;
    logic [1:0]  write_card_state;
    logic [3:0]  write_card_addr;
    logic        update_cards_en;
    logic        wait_for_click_en;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        card_pressed;
    logic [3:0]  card_clicked_address;
    logic [11:0] card_clicked_color;
    logic [3:0]  disp_addr;
    logic [1:0]  disp_state;
    logic [11:0] disp_color;

    modport master (
        output color_wr_en, color_wr_addr, color_wr_data,
        output write_card_en, write_card_state, write_card_addr,
        output update_cards_en, wait_for_click_en,
        output mouse_xpos, mouse_ypos, mouse_left, disp_addr,
        input  card_pressed, card_clicked_address, card_clicked_color,
        input  disp_state, disp_color
    );

    modport slave (
        input  color_wr_en, color_wr_addr, color_wr_data,
        input  write_card_en, write_card_state, write_card_addr,
        input  update_cards_en, wait_for_click_en,
        input  mouse_xpos, mouse_ypos, mouse_left, disp_addr,
        output card_pressed, card_clicked_address, card_clicked_color,
        output disp_state, disp_color
    );
endinterface

// File: rtl/card_hit_scanner.sv
// Click FSM: walks the cards one per cycle with running geometry counters and
// reports the first card whose rectangle contains the latched click position.
module card_hit_scanner
    import card_board_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        click_rise,
    input  logic        enable,
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic        hit_valid,
    output logic [3:0]  hit_idx
);

    scan_state_e state_r, state_n;
    logic [11:0] x_r, y_r, left_r, top_r;
    logic [3:0]  idx_r;
    logic [1:0]  col_r, row_r;
    logic        hit_s;

    // Right and bottom edges are exclusive, so gap pixels and edge pixels miss.
    assign hit_s = (x_r >= left_r) && (x_r < left_r + 12'(CARD_W)) &&
                   (y_r >= top_r)  && (y_r < top_r  + 12'(CARD_H));

    assign hit_valid = (state_r == SCAN_HIT);
    assign hit_idx   = idx_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= SCAN_IDLE;
        else     state_r <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            SCAN_IDLE: begin
                if (click_rise && enable) state_n = SCAN_RUN;
                else                      state_n = SCAN_IDLE;
            end
            SCAN_RUN: begin
                if (!enable)                            state_n = SCAN_IDLE;
                else if (hit_s)                         state_n = SCAN_HIT;
                else if (idx_r == 4'(N_CARDS - 1))      state_n = SCAN_IDLE;
                else                                    state_n = SCAN_RUN;
            end
            SCAN_HIT: state_n = SCAN_IDLE;
            default:  state_n = SCAN_IDLE;
        endcase
    end

    // Click position latch and card geometry counters
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= 12'd0;
            y_r    <= 12'd0;
            idx_r  <= 4'd0;
            col_r  <= 2'd0;
            row_r  <= 2'd0;
            left_r <= 12'(X0);
            top_r  <= 12'(Y0);
        end else if (state_r == SCAN_IDLE && state_n == SCAN_RUN) begin
            x_r    <= x;
            y_r    <= y;
            idx_r  <= 4'd0;
            col_r  <= 2'd0;
            row_r  <= 2'd0;
            left_r <= 12'(X0);
            top_r  <= 12'(Y0);
        end else if (state_r == SCAN_RUN && state_n == SCAN_RUN) begin
            idx_r <= idx_r + 4'd1;
            if (col_r == 2'(COLS - 1)) begin
                col_r  <= 2'd0;
                row_r  <= row_r + 2'd1;
                left_r <= 12'(X0);
                top_r  <= top_r + 12'(CARD_H + GAP);
            end else begin
                col_r  <= col_r + 2'd1;
                left_r <= left_r + 12'(CARD_W + GAP);
            end
        end
    end

endmodule

// File: rtl/card_board.sv
// Card-board store: per-card state and colour, display snapshot with a
// registered read port, and the click responder producing card_pressed.
module card_board
    import card_board_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    card_board_if.slave bus
);

    logic [1:0]  work_state_r [N_CARDS];
    logic [1:0]  snap_state_r [N_CARDS];
    logic [11:0] color_r      [N_CARDS];
    logic        mouse_prev_r;
    logic        click_rise_s;
    logic        hit_valid_s;
    logic [3:0]  hit_idx_s;
    logic        press_ok_s;
    logic        card_pressed_r;
    logic [3:0]  clicked_addr_r;
    logic [11:0] clicked_color_r;
    logic [1:0]  disp_state_r;
    logic [11:0] disp_color_r;

    assign click_rise_s = bus.mouse_left & ~mouse_prev_r;

    // Previous mouse button level for edge detection
    always_ff @(posedge clk) begin
        if (rst) mouse_prev_r <= 1'b0;
        else     mouse_prev_r <= bus.mouse_left;
    end

    card_hit_scanner u_scan (
        .clk        (clk),
        .rst        (rst),
        .click_rise (click_rise_s),
        .enable     (bus.wait_for_click_en),
        .x          (bus.mouse_xpos),
        .y          (bus.mouse_ypos),
        .hit_valid  (hit_valid_s),
        .hit_idx    (hit_idx_s)
    );

    // Card store; a state write on the same card overrides the COVERED from a colour load,
    // and the snapshot copies pre-write states.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CARDS; i++) begin
                work_state_r[i] <= CARD_BLANK;
                snap_state_r[i] <= CARD_BLANK;
                color_r[i]      <= 12'd0;
            end
        end else begin
            for (int i = 0; i < N_CARDS; i++) begin
                if (bus.color_wr_en && bus.color_wr_addr == 4'(i)) begin
                    color_r[i]      <= bus.color_wr_data;
                    work_state_r[i] <= CARD_COVERED;
                end
                if (bus.write_card_en && bus.write_card_addr == 4'(i)) begin
                    work_state_r[i] <= bus.write_card_state;
                end
                if (bus.update_cards_en) begin
                    snap_state_r[i] <= work_state_r[i];
                end
            end
        end
    end

    // Final check in the HIT state: still enabled and the card is covered
    always_comb begin
        press_ok_s = 1'b0;
        if (hit_valid_s && bus.wait_for_click_en && addr_valid(hit_idx_s)) begin
            press_ok_s = (work_state_r[hit_idx_s] == CARD_COVERED);
        end else begin
            press_ok_s = 1'b0;
        end
    end

    // Click result registers; address and colour hold until the next pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            card_pressed_r  <= 1'b0;
            clicked_addr_r  <= 4'd0;
            clicked_color_r <= 12'd0;
        end else begin
            card_pressed_r <= press_ok_s;
            if (press_ok_s) begin
                clicked_addr_r  <= hit_idx_s;
                clicked_color_r <= color_r[hit_idx_s];
            end
        end
    end

    // Renderer read port
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_state_r <= 2'b00;
            disp_color_r <= 12'd0;
        end else if (addr_valid(bus.disp_addr)) begin
            disp_state_r <= snap_state_r[bus.disp_addr];
            disp_color_r <= color_r[bus.disp_addr];
        end else begin
            disp_state_r <= 2'b00;
            disp_color_r <= 12'd0;
        end
    end

    assign bus.card_pressed         = card_pressed_r;
    assign bus.card_clicked_address = clicked_addr_r;
    assign bus.card_clicked_color   = clicked_color_r;
    assign bus.disp_state           = disp_state_r;
    assign bus.disp_color           = disp_color_r;

endmodule

// File: tb/tb_card_board.sv
// Directed self-checking bench for card_board.
module tb_card_board;
    import card_board_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pulses;
    int   first;

    card_board_if bus ();

    card_board dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Click at (x,y), button held for 'hold' cycles, watching 'window' cycles after the sampling edge
    task automatic click_watch(input logic [11:0] x, input logic [11:0] y, input int hold,
                               input int window, output int npulse, output int first_c);
        bus.mouse_xpos = x;
        bus.mouse_ypos = y;
        bus.mouse_left = 1'b1;
        step(1);
        npulse  = 0;
        first_c = -1;
        for (int c = 1; c <= window; c++) begin
            if (c >= hold) bus.mouse_left = 1'b0;
            step(1);
            if (bus.card_pressed === 1'b1) begin
                npulse++;
                if (first_c < 0) first_c = c;
            end
        end
        bus.mouse_left = 1'b0;
    endtask

    task automatic read_disp(input logic [3:0] a);
        bus.disp_addr = a;
        step(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.color_wr_en = 1'b0;      bus.color_wr_addr = 4'd0;   bus.color_wr_data = 12'd0;
        bus.write_card_en = 1'b0;    bus.write_card_state = 2'b00; bus.write_card_addr = 4'd0;
        bus.update_cards_en = 1'b0;  bus.wait_for_click_en = 1'b0;
        bus.mouse_xpos = 12'd0;      bus.mouse_ypos = 12'd0;     bus.mouse_left = 1'b0;
        bus.disp_addr = 4'd5;
        rst = 1'b1;
        step(2);
        rst = 1'b0;

        // 1: reset state, colour load, snapshot timing
        check("rst_pressed", 32'(bus.card_pressed), 32'd0);
        check("rst_addr", 32'(bus.card_clicked_address), 32'd0);
        check("rst_color", 32'(bus.card_clicked_color), 32'd0);
        check("rst_disp_state", 32'(bus.disp_state), 32'd0);
        check("rst_disp_color", 32'(bus.disp_color), 32'd0);
        bus.color_wr_en = 1'b1; bus.color_wr_addr = 4'd5; bus.color_wr_data = 12'hF00;
        step(1);
        bus.color_wr_en = 1'b0;
        read_disp(4'd5);
        check("pre_update_state", 32'(bus.disp_state), 32'd0);
        check("load_color", 32'(bus.disp_color), 32'hF00);
        bus.update_cards_en = 1'b1;
        step(1);
        bus.update_cards_en = 1'b0;
        check("update_edge_state", 32'(bus.disp_state), 32'd0);
        step(1);
        check("post_update_state", 32'(bus.disp_state), 32'd1);

        // 2: click on card 5, latency 7
        bus.wait_for_click_en = 1'b1;
        click_watch(12'd234, 12'd266, 1, 12, pulses, first);
        check("c5_pulses", 32'(pulses), 32'd1);
        check("c5_latency", 32'(first), 32'd7);
        check("c5_addr", 32'(bus.card_clicked_address), 32'd5);
        check("c5_color", 32'(bus.card_clicked_color), 32'hF00);
        click_watch(12'd70, 12'd70, 1, 6, pulses, first);
        check("blank_pulses", 32'(pulses), 32'd0);

        // 3: uncovered card, gap, right edge, last inside pixel
        bus.write_card_en = 1'b1; bus.write_card_addr = 4'd5; bus.write_card_state = 2'b11;
        step(1);
        bus.write_card_en = 1'b0;
        click_watch(12'd234, 12'd266, 1, 12, pulses, first);
        check("uncovered_pulses", 32'(pulses), 32'd0);
        check("held_addr", 32'(bus.card_clicked_address), 32'd5);
        bus.color_wr_en = 1'b1; bus.color_wr_addr = 4'd0; bus.color_wr_data = 12'h0F0;
        step(1);
        bus.color_wr_en = 1'b0;
        click_watch(12'd197, 12'd70, 1, 16, pulses, first);
        check("gap_pulses", 32'(pulses), 32'd0);
        click_watch(12'd192, 12'd70, 1, 16, pulses, first);
        check("right_edge_pulses", 32'(pulses), 32'd0);
        click_watch(12'd191, 12'd223, 1, 6, pulses, first);
        check("inside_pulses", 32'(pulses), 32'd1);
        check("c0_latency", 32'(first), 32'd2);
        check("c0_addr", 32'(bus.card_clicked_address), 32'd0);
        check("c0_color", 32'(bus.card_clicked_color), 32'h0F0);

        // 4: held button, disabled clicks
        click_watch(12'd70, 12'd70, 100, 110, pulses, first);
        check("held_pulses", 32'(pulses), 32'd1);
        bus.wait_for_click_en = 1'b0;
        click_watch(12'd70, 12'd70, 1, 6, pulses, first);
        check("disabled_pulses", 32'(pulses), 32'd0);

        // 5: abort during scan, good card-11 click, reset mid-scan
        bus.wait_for_click_en = 1'b1;
        bus.color_wr_en = 1'b1; bus.color_wr_addr = 4'd11; bus.color_wr_data = 12'h0AB;
        step(1);
        bus.color_wr_en = 1'b0;
        bus.mouse_xpos = 12'd554; bus.mouse_ypos = 12'd458; bus.mouse_left = 1'b1;
        step(1);
        bus.mouse_left = 1'b0;
        step(3);
        bus.wait_for_click_en = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            if (bus.card_pressed === 1'b1) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        bus.wait_for_click_en = 1'b1;
        click_watch(12'd554, 12'd458, 1, 16, pulses, first);
        check("c11_pulses", 32'(pulses), 32'd1);
        check("c11_latency", 32'(first), 32'd13);
        check("c11_addr", 32'(bus.card_clicked_address), 32'd11);
        check("c11_color", 32'(bus.card_clicked_color), 32'h0AB);
        bus.mouse_left = 1'b1;
        step(1);
        bus.mouse_left = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midscan_fsm", 32'(dut.u_scan.state_r), 32'(SCAN_IDLE));
        check("midscan_pressed", 32'(bus.card_pressed), 32'd0);
        check("midscan_addr", 32'(bus.card_clicked_address), 32'd0);
        check("midscan_color", 32'(bus.card_clicked_color), 32'd0);
        check("midscan_disp_state", 32'(bus.disp_state), 32'd0);
        check("midscan_disp_color", 32'(bus.disp_color), 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            if (bus.card_pressed === 1'b1) pulses++;
        end
        check("midscan_pulses", 32'(pulses), 32'd0);

        // 6: simultaneous strobes, same-cycle update exclusion, out-of-range write
        bus.color_wr_en = 1'b1; bus.color_wr_addr = 4'd3; bus.color_wr_data = 12'h123;
        bus.write_card_en = 1'b1; bus.write_card_addr = 4'd3; bus.write_card_state = 2'b10;
        step(1);
        bus.color_wr_en = 1'b0; bus.write_card_en = 1'b0;
        bus.update_cards_en = 1'b1;
        step(1);
        bus.update_cards_en = 1'b0;
        read_disp(4'd3);
        check("both_state", 32'(bus.disp_state), 32'd2);
        check("both_color", 32'(bus.disp_color), 32'h123);
        bus.write_card_en = 1'b1; bus.write_card_addr = 4'd3; bus.write_card_state = 2'b11;
        bus.update_cards_en = 1'b1;
        step(1);
        bus.write_card_en = 1'b0; bus.update_cards_en = 1'b0;
        read_disp(4'd3);
        check("same_cycle_excluded", 32'(bus.disp_state), 32'd2);
        bus.write_card_en = 1'b1; bus.write_card_addr = 4'd13; bus.write_card_state = 2'b01;
        bus.color_wr_en = 1'b1; bus.color_wr_addr = 4'd13; bus.color_wr_data = 12'hFFF;
        step(1);
        bus.write_card_en = 1'b0; bus.color_wr_en = 1'b0;
        bus.update_cards_en = 1'b1;
        step(1);
        bus.update_cards_en = 1'b0;
        for (int a = 0; a < N_CARDS; a++) begin
            read_disp(4'(a));
            check($sformatf("oor_state_%0d", a), 32'(bus.disp_state), (a == 3) ? 32'd3 : 32'd0);
        end
        read_disp(4'd13);
        check("oor_read_state", 32'(bus.disp_state), 32'd0);
        check("oor_read_color", 32'(bus.disp_color), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
